// File: rtl/mem_port_arbiter_pkg.sv
// Shared memory-port definitions for the sparse matrix decoder's load-port arbiter.
// Address/data/tag widths and the fixed requester index assignment.
package mem_port_arbiter_pkg;

    localparam int MEM_ADDR_W = 48;
    localparam int MEM_DATA_W = 64;
    localparam int MEM_TAG_W  = 2;

    typedef enum logic [MEM_TAG_W-1:0] {
        REQ_CODE      = 2'd0,
        REQ_ARG       = 2'd1,
        REQ_FZIP_CODE = 2'd2,
        REQ_FZIP_ARG  = 2'd3
    } req_id_e;

    function automatic logic addr_aligned(input logic [MEM_ADDR_W-1:0] addr);
        return addr[2:0] == 3'b000;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_picker.sv
// Combinational round-robin picker: the first eligible index at or after ptr, wrapping.
module round_robin_picker #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     eligible,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] winner,
    output logic             any
);

    int unsigned best_d;
    int unsigned d;

    // Pick the eligible index with the smallest forward distance from ptr.
    always_comb begin
        best_d = N;
        d      = 0;
        winner = '0;
        any    = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (i >= 32'(ptr)) d = i - 32'(ptr);
            else               d = i + N - 32'(ptr);
            if (eligible[i] && d < best_d) begin
                best_d = d;
                winner = IDX_W'(i);
                any    = 1'b1;
            end
        end
    end

    always_comb begin
        grant = '0;
        for (int unsigned i = 0; i < N; i++) begin
            grant[i] = any && (winner == IDX_W'(i));
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one tagged memory load port among NUM_REQ stream readers.
// Define MEM_PORT_ARBITER_CHECK_EN to enable the sticky protocol-error flag on err.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TAG_W   = 2,
    parameter int MAX_OUT = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_ld,
    input  logic [MEM_ADDR_W*NUM_REQ-1:0] req_addr,
    output logic [NUM_REQ-1:0]            req_stall,
    output logic                          req_mem_ld,
    output logic [MEM_ADDR_W-1:0]         req_mem_addr,
    output logic [TAG_W-1:0]              req_mem_tag,
    input  logic                          req_mem_stall,
    input  logic                          rsp_mem_push,
    input  logic [TAG_W-1:0]              rsp_mem_tag,
    input  logic [MEM_DATA_W-1:0]         rsp_mem_q,
    output logic                          rsp_mem_stall,
    output logic [NUM_REQ-1:0]            rsp_push,
    output logic [MEM_DATA_W-1:0]         rsp_q,
    input  logic [NUM_REQ-1:0]            rsp_stall,
    output logic                          busy,
    output logic                          err
);

    localparam int CW = $clog2(MAX_OUT + 1);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [CW-1:0] MAX_CRED = CW'(MAX_OUT);
    localparam logic [PW-1:0] LAST_IDX = PW'(NUM_REQ - 1);

    logic                  slot_valid;
    logic [MEM_ADDR_W-1:0] slot_addr;
    logic [TAG_W-1:0]      slot_tag;
    logic [PW-1:0]         rr_ptr;
    logic [CW-1:0]         credit [NUM_REQ];

    logic [NUM_REQ-1:0]    eligible;
    logic [NUM_REQ-1:0]    grant;
    logic [PW-1:0]         winner;
    logic                  any_elig;
    logic                  slot_free;
    logic                  grant_ok;
    logic [MEM_ADDR_W-1:0] win_addr;
    logic [NUM_REQ-1:0]    hit;
    logic                  any_credit;

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            eligible[i] = req_ld[i] && (credit[i] < MAX_CRED);
        end
    end

    round_robin_picker #(
        .N     (NUM_REQ),
        .IDX_W (PW)
    ) u_picker (
        .eligible (eligible),
        .ptr      (rr_ptr),
        .grant    (grant),
        .winner   (winner),
        .any      (any_elig)
    );

    assign slot_free = !slot_valid || !req_mem_stall;
    assign grant_ok  = slot_free && any_elig;
    assign req_stall = ~(grant & {NUM_REQ{grant_ok}});

    always_comb begin
        win_addr = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) win_addr = req_addr[i*MEM_ADDR_W +: MEM_ADDR_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_valid <= 1'b0;
            slot_addr  <= '0;
            slot_tag   <= '0;
            rr_ptr     <= '0;
        end else if (slot_free) begin
            slot_valid <= any_elig;
            if (any_elig) begin
                slot_addr <= win_addr;
                slot_tag  <= TAG_W'(winner);
                rr_ptr    <= (winner == LAST_IDX) ? '0 : winner + 1'b1;
            end
        end
    end

    assign req_mem_ld   = slot_valid;
    assign req_mem_addr = slot_addr;
    assign req_mem_tag  = slot_tag;

    // Out-of-range tags match no requester, so they are dropped without stall or credit change.
    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            hit[i] = rsp_mem_push && (rsp_mem_tag == TAG_W'(i));
        end
    end

    assign rsp_push      = hit & ~rsp_stall;
    assign rsp_mem_stall = |(hit & rsp_stall);
    assign rsp_q         = rsp_mem_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) credit[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (grant_ok && grant[i] && !rsp_push[i]) begin
                    credit[i] <= credit[i] + 1'b1;
                end else if (rsp_push[i] && !(grant_ok && grant[i]) && credit[i] != '0) begin
                    credit[i] <= credit[i] - 1'b1;
                end
            end
        end
    end

    always_comb begin
        any_credit = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (credit[i] != '0) any_credit = 1'b1;
        end
    end

    assign busy = slot_valid || any_credit;

`ifdef MEM_PORT_ARBITER_CHECK_EN
    logic err_q;
    logic bad_cred;
    logic bad_tag;
    logic bad_align;

    always_comb begin
        bad_cred = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (hit[i] && credit[i] == '0) bad_cred = 1'b1;
        end
    end

    assign bad_tag   = rsp_mem_push && !(|hit);
    assign bad_align = grant_ok && !addr_aligned(win_addr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (bad_cred || bad_tag || bad_align) begin
            err_q <= 1'b1;
`ifndef SYNTHESIS
            $display("mem_port_arbiter: protocol error (credit=%0b tag=%0b align=%0b) at %0t",
                     bad_cred, bad_tag, bad_align, $time);
`endif
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: behavioural model plus directed scenarios.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    localparam int N    = 4;
    localparam int TW   = 2;
    localparam int MAXO = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_ld;
    logic [48*N-1:0] req_addr;
    logic [N-1:0]    req_stall;
    logic            req_mem_ld;
    logic [47:0]     req_mem_addr;
    logic [TW-1:0]   req_mem_tag;
    logic            req_mem_stall;
    logic            rsp_mem_push;
    logic [TW-1:0]   rsp_mem_tag;
    logic [63:0]     rsp_mem_q;
    logic            rsp_mem_stall;
    logic [N-1:0]    rsp_push;
    logic [63:0]     rsp_q;
    logic [N-1:0]    rsp_stall;
    logic            busy;
    logic            err;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .NUM_REQ (N),
        .TAG_W   (TW),
        .MAX_OUT (MAXO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_ld        (req_ld),
        .req_addr      (req_addr),
        .req_stall     (req_stall),
        .req_mem_ld    (req_mem_ld),
        .req_mem_addr  (req_mem_addr),
        .req_mem_tag   (req_mem_tag),
        .req_mem_stall (req_mem_stall),
        .rsp_mem_push  (rsp_mem_push),
        .rsp_mem_tag   (rsp_mem_tag),
        .rsp_mem_q     (rsp_mem_q),
        .rsp_mem_stall (rsp_mem_stall),
        .rsp_push      (rsp_push),
        .rsp_q         (rsp_q),
        .rsp_stall     (rsp_stall),
        .busy          (busy),
        .err           (err)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: one slot, a pointer, and a credit count per requester.
    bit          m_valid;
    logic [47:0] m_addr;
    int          m_tag;
    int          m_ptr;
    int          m_cred [N];
    bit          m_err;

    function automatic bit bit_of(input logic [N-1:0] v, input int i);
        return ((v >> i) & N'(1)) != '0;
    endfunction

    function automatic logic [47:0] addr_of(input int i);
        return 48'(req_addr >> (48 * i));
    endfunction

    function automatic int pick();
        for (int k = 0; k < N; k++) begin
            int j;
            j = (m_ptr + k) % N;
            if (bit_of(req_ld, j) && m_cred[j] < MAXO) return j;
        end
        return -1;
    endfunction

    function automatic int granted();
        if (!m_valid || !req_mem_stall) return pick();
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int g;
        int t;
        if (!rst_n) begin
            m_valid = 1'b0;
            m_addr  = '0;
            m_tag   = 0;
            m_ptr   = 0;
            for (int i = 0; i < N; i++) m_cred[i] = 0;
            m_err   = 1'b0;
        end else begin
            g = granted();
            t = int'(rsp_mem_tag);
            if (rsp_mem_push && (t >= N || m_cred[t] == 0)) m_err = 1'b1;
            if (g >= 0 && (addr_of(g) % 8) != 0) m_err = 1'b1;
            if (!m_valid || !req_mem_stall) begin
                m_valid = (g >= 0);
                if (g >= 0) begin
                    m_addr = addr_of(g);
                    m_tag  = g;
                    m_ptr  = (g + 1) % N;
                    m_cred[g] = m_cred[g] + 1;
                end
            end
            if (rsp_mem_push && t < N && !bit_of(rsp_stall, t) && m_cred[t] > 0)
                m_cred[t] = m_cred[t] - 1;
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        int          g;
        int          t;
        logic [N-1:0] e_stall;
        logic [N-1:0] e_push;
        bit          e_mstall;
        bit          e_busy;
        bit          e_err;
        g = granted();
        t = int'(rsp_mem_tag);
        e_stall = '1;
        if (g >= 0) e_stall = e_stall & ~(N'(1) << g);
        e_push   = '0;
        e_mstall = 1'b0;
        if (rsp_mem_push && t < N) begin
            if (bit_of(rsp_stall, t)) e_mstall = 1'b1;
            else                      e_push   = N'(1) << t;
        end
        e_busy = m_valid;
        for (int i = 0; i < N; i++) if (m_cred[i] != 0) e_busy = 1'b1;
`ifdef MEM_PORT_ARBITER_CHECK_EN
        e_err = m_err;
`else
        e_err = 1'b0;
`endif
        check("req_mem_ld",    64'(req_mem_ld),    64'(m_valid));
        check("req_mem_addr",  64'(req_mem_addr),  64'(m_addr));
        check("req_mem_tag",   64'(req_mem_tag),   64'(m_tag));
        check("req_stall",     64'(req_stall),     64'(e_stall));
        check("rsp_push",      64'(rsp_push),      64'(e_push));
        check("rsp_mem_stall", 64'(rsp_mem_stall), 64'(e_mstall));
        check("rsp_q",         rsp_q,              rsp_mem_q);
        check("busy",          64'(busy),          64'(e_busy));
        check("err",           64'(err),           64'(e_err));
    end

    // Inputs change 2 ns after each rising edge.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic set_addr(input int i, input logic [47:0] a);
        req_addr[48*i +: 48] = a;
    endtask

    int rr_tags [6] = '{0, 1, 2, 3, 0, 1};

    initial begin
        rst_n         = 1'b0;
        req_ld        = '0;
        req_addr      = '0;
        req_mem_stall = 1'b0;
        rsp_mem_push  = 1'b0;
        rsp_mem_tag   = '0;
        rsp_mem_q     = '0;
        rsp_stall     = '0;
        cyc();
        #1;
        check("reset req_mem_ld", 64'(req_mem_ld), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset err", 64'(err), 64'd0);
        cyc();
        rst_n = 1'b1;
        cyc();

        // Single requester round trip.
        set_addr(0, 48'h1000);
        req_ld = 4'b0001;
        #1 check("single req_stall", 64'(req_stall), 64'hE);
        cyc();
        req_ld = '0;
        #1;
        check("single ld", 64'(req_mem_ld), 64'd1);
        check("single addr", 64'(req_mem_addr), 64'h1000);
        check("single tag", 64'(req_mem_tag), 64'd0);
        cyc();
        rsp_mem_push = 1'b1;
        rsp_mem_tag  = 2'd0;
        rsp_mem_q    = 64'hDEAD_BEEF_0123_4567;
        #1;
        check("single rsp_push", 64'(rsp_push), 64'h1);
        check("single rsp_q", rsp_q, 64'hDEAD_BEEF_0123_4567);
        cyc();
        rsp_mem_push = 1'b0;
        #1 check("single busy low", 64'(busy), 64'd0);

        // All four requesting: strict rotation.
        do_reset();
        for (int i = 0; i < N; i++) set_addr(i, 48'(48'h100 * (i + 1)));
        req_ld = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            cyc();
            #1 check("rr tag", 64'(req_mem_tag), 64'(rr_tags[k]));
        end
        req_ld = '0;
        cyc();

        // Memory stall holds the slot.
        do_reset();
        set_addr(2, 48'h2040);
        req_ld = 4'b0100;
        cyc();
        req_mem_stall = 1'b1;
        set_addr(3, 48'h3000);
        req_ld = 4'b1111;
        #1 check("stall all stalled", 64'(req_stall), 64'hF);
        for (int k = 0; k < 3; k++) begin
            cyc();
            #1;
            check("stall addr", 64'(req_mem_addr), 64'h2040);
            check("stall tag", 64'(req_mem_tag), 64'd2);
            check("stall req_stall", 64'(req_stall), 64'hF);
        end
        req_mem_stall = 1'b0;
        #1 check("stall release winner", 64'(req_stall), 64'h7);
        cyc();
        #1 check("stall next tag", 64'(req_mem_tag), 64'd3);
        req_ld = '0;
        cyc();

        // Credit limit on requester 1.
        do_reset();
        set_addr(0, 48'h1000);
        set_addr(1, 48'h1108);
        req_ld = 4'b0010;
        repeat (8) cyc();
        req_ld = 4'b0011;
        #1 check("credit full", 64'(req_stall), 64'hE);
        for (int k = 0; k < 3; k++) begin
            cyc();
            #1 check("credit req0 wins", 64'(req_mem_tag), 64'd0);
        end
        rsp_mem_push = 1'b1;
        rsp_mem_tag  = 2'd1;
        #1 check("credit still full", 64'(req_stall), 64'hE);
        cyc();
        rsp_mem_push = 1'b0;
        #1 check("credit freed", 64'(req_stall), 64'hD);
        cyc();
        #1 check("credit req1 tag", 64'(req_mem_tag), 64'd1);
        req_ld = '0;
        cyc();

        // Response back-pressure and simultaneous grant/response.
        do_reset();
        set_addr(3, 48'h3000);
        req_ld = 4'b1000;
        cyc();
        req_ld = '0;
        cyc();
        rsp_mem_push = 1'b1;
        rsp_mem_tag  = 2'd3;
        rsp_stall    = 4'b1000;
        #1;
        check("rstall mem_stall", 64'(rsp_mem_stall), 64'd1);
        check("rstall push", 64'(rsp_push), 64'd0);
        cyc();
        #1 check("rstall busy", 64'(busy), 64'd1);
        rsp_stall = '0;
        #1;
        check("rstall release push", 64'(rsp_push), 64'h8);
        check("rstall release mem_stall", 64'(rsp_mem_stall), 64'd0);
        cyc();
        rsp_mem_push = 1'b0;
        #1 check("rstall busy low", 64'(busy), 64'd0);
        req_ld = 4'b1000;
        cyc();
        rsp_mem_push = 1'b1;
        cyc();
        req_ld = '0;
        rsp_mem_push = 1'b0;
        cyc();
        #1 check("overlap one credit left", 64'(busy), 64'd1);
        rsp_mem_push = 1'b1;
        cyc();
        rsp_mem_push = 1'b0;
        #1 check("overlap drained", 64'(busy), 64'd0);

        // Reset with a load in flight; late response is still forwarded.
        set_addr(0, 48'h4000);
        req_ld = 4'b0001;
        cyc();
        req_ld = '0;
        rst_n  = 1'b0;
        cyc();
        rst_n = 1'b1;
        rsp_mem_push = 1'b1;
        rsp_mem_tag  = 2'd0;
        rsp_mem_q    = 64'h0000_CAFE_F00D_0001;
        #1 check("late rsp_push", 64'(rsp_push), 64'h1);
        cyc();
        rsp_mem_push = 1'b0;
        #1 check("late busy", 64'(busy), 64'd0);

`ifdef MEM_PORT_ARBITER_CHECK_EN
        do_reset();
        #1 check("err clear", 64'(err), 64'd0);
        rsp_mem_push = 1'b1;
        rsp_mem_tag  = 2'd1;
        cyc();
        rsp_mem_push = 1'b0;
        #1 check("err set", 64'(err), 64'd1);
        cyc();
        #1 check("err held", 64'(err), 64'd1);
        rst_n = 1'b0;
        #1;
        check("err reset", 64'(err), 64'd0);
        check("err reset ld", 64'(req_mem_ld), 64'd0);
        check("err reset busy", 64'(busy), 64'd0);
        cyc();
        rst_n = 1'b1;
        cyc();
`endif

        cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
